// File: rtl/pll_trim_controller_if.sv
// Bus for the PLL trim controller: loop enable, the osc reference and the
// div target go in, and the thermometer trim, its index and lock come out.
interface pll_trim_controller_if #(
  parameter int DIV_W  = 5,
  parameter int TRIM_W = 26
) ();
  localparam int IDX_W = $clog2(TRIM_W + 1);

  logic              enable;
  logic              osc;
  logic [DIV_W-1:0]  div;
  logic [TRIM_W-1:0] trim;
  logic [IDX_W-1:0]  trim_idx;
  logic              lock;

  // The master drives the loop controls and observes the trim result.
  modport master (output enable, osc, div, input trim, trim_idx, lock);
  // The slave is the controller itself.
  modport slave  (input enable, osc, div, output trim, trim_idx, lock);
endinterface

// File: rtl/pll_trim_controller.sv
// PLL trim controller: measures the osc period in clock cycles, compares it
// with the div target and steps a thermometer-coded trim up or down until
// the period sits inside the lock window.
module pll_trim_controller #(
  parameter int DIV_W       = 5,
  parameter int TRIM_W      = 26,
  parameter int CNT_W       = 8,
  parameter int TOL         = 1,
  parameter int COARSE_THR  = 4,
  parameter int COARSE_STEP = 4,
  parameter int LOCK_N      = 4,
  parameter int TRIM_INIT   = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  pll_trim_controller_if.slave  bus
);
  localparam int IDX_W = $clog2(TRIM_W + 1);
  localparam int MW    = (CNT_W > DIV_W) ? CNT_W : DIV_W;
  localparam int LW    = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [MW:0]      TOL_V    = TOL[MW:0];
  localparam logic [MW:0]      THR_V    = COARSE_THR[MW:0];
  localparam logic [IDX_W:0]   STEP_C   = COARSE_STEP[IDX_W:0];
  localparam logic [IDX_W:0]   STEP_F   = 1;
  localparam logic [IDX_W:0]   IDX_MAX  = TRIM_W[IDX_W:0];
  localparam logic [IDX_W-1:0] IDX_TOP  = TRIM_W[IDX_W-1:0];
  localparam logic [IDX_W-1:0] IDX_RST  = TRIM_INIT[IDX_W-1:0];
  localparam logic [LW-1:0]    LOCK_V   = LOCK_N[LW-1:0];

  // Thermometer code: the lowest n bits set.
  function automatic logic [TRIM_W-1:0] thermo(input logic [IDX_W-1:0] n);
    logic [TRIM_W-1:0] t;
    t = '0;
    for (int i = 0; i < TRIM_W; i++) t[i] = (IDX_W'(i) < n);
    return t;
  endfunction

  localparam logic [TRIM_W-1:0] TRIM_RST = thermo(IDX_RST);

  typedef enum logic [1:0] {IDLE, ARM, TRACK} state_t;

  state_t            state_q;
  logic              sync1_q, sync2_q, tick_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LW-1:0]     lockCnt_q, lockCnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TRIM_W-1:0] trim_q;
  logic              lock_q;

  logic [CNT_W-1:0]  meas;
  logic              measSat;
  logic [MW-1:0]     measExt, divExt;
  logic signed [MW:0] err;
  logic [MW:0]       absErr;
  logic              inWindow;
  logic [IDX_W:0]    step, idxW, sum, diff;

  // Bring osc into the clock domain and flag the cycle after its rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= bus.osc;
      sync2_q <= sync1_q;
      tick_q  <= sync1_q & ~sync2_q;
    end
  end

  // Period error against div and the trim/lock values a tick would produce.
  always_comb begin
    meas     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    measSat  = (meas == CNT_MAX);
    measExt  = MW'(meas);
    divExt   = MW'(bus.div);
    err      = $signed({1'b0, measExt}) - $signed({1'b0, divExt});
    absErr   = (err < 0) ? $unsigned(-err) : $unsigned(err);
    inWindow = (absErr <= TOL_V);
    step     = (absErr >= THR_V) ? STEP_C : STEP_F;
    idxW     = {1'b0, idx_q};
    sum      = idxW + step;
    diff     = idxW - step;
    idx_d    = idx_q;
    if (!inWindow) begin
      if (err > 0) idx_d = (sum > IDX_MAX) ? IDX_TOP : sum[IDX_W-1:0];
      else         idx_d = (idxW < step) ? '0 : diff[IDX_W-1:0];
    end
    if (!inWindow || measSat) lockCnt_d = '0;
    else if (lockCnt_q == LOCK_V) lockCnt_d = LOCK_V;
    else lockCnt_d = lockCnt_q + 1'b1;
  end

  // Loop state machine: period counter, trim stepping and lock flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lockCnt_q <= '0;
      idx_q     <= IDX_RST;
      trim_q    <= TRIM_RST;
      lock_q    <= 1'b0;
    end else if (!bus.enable) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lockCnt_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      if (tick_q) cnt_q <= '0;
      else if (state_q != IDLE && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          lockCnt_q <= '0;
          lock_q    <= 1'b0;
          state_q   <= ARM;
        end
        ARM: begin
          lockCnt_q <= '0;
          lock_q    <= 1'b0;
          if (tick_q) state_q <= TRACK;
        end
        TRACK: begin
          if (tick_q) begin
            idx_q     <= idx_d;
            trim_q    <= thermo(idx_d);
            lockCnt_q <= lockCnt_d;
            lock_q    <= (lockCnt_d == LOCK_V);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.trim     = trim_q;
  assign bus.trim_idx = idx_q;
  assign bus.lock     = lock_q;
endmodule

// File: tb/tb_pll_trim_controller.sv
// Bench for pll_trim_controller: drives osc with whole-cycle periods and
// predicts trim/lock from the measured period with a plain arithmetic model.
module tb_pll_trim_controller;
  localparam int DIV_W       = 5;
  localparam int TRIM_W      = 26;
  localparam int CNT_MAX     = 255;
  localparam int TOL         = 1;
  localparam int COARSE_THR  = 4;
  localparam int COARSE_STEP = 4;
  localparam int LOCK_N      = 4;
  localparam int TRIM_INIT   = 13;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pll_trim_controller_if #(.DIV_W(DIV_W), .TRIM_W(TRIM_W)) bus ();

  pll_trim_controller #(
    .DIV_W(DIV_W), .TRIM_W(TRIM_W), .CNT_W(8), .TOL(TOL),
    .COARSE_THR(COARSE_THR), .COARSE_STEP(COARSE_STEP),
    .LOCK_N(LOCK_N), .TRIM_INIT(TRIM_INIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;

  bit modelEnabled  = 1'b0;
  bit modelTracking = 1'b0;
  int modelIdx      = TRIM_INIT;
  int modelLockCnt  = 0;
  int prevPeriod    = 0;
  int curDiv        = 8;

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] thermoOf(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // Compare all three outputs against the model.
  task automatic checkAll(input string tag);
    checkOutput({tag, ".idx"}, 64'(bus.trim_idx), 64'(modelIdx));
    checkOutput({tag, ".trim"}, 64'(bus.trim), thermoOf(modelIdx));
    checkOutput({tag, ".lock"}, 64'(bus.lock),
                64'(modelEnabled && modelTracking && modelLockCnt == LOCK_N));
  endtask

  // Model reaction to an osc rising edge, given the period that just ended.
  task automatic modelTick();
    int meas, err, mag, stepSize;
    if (!modelEnabled) return;
    if (!modelTracking) begin
      modelTracking = 1'b1;
      return;
    end
    meas = (prevPeriod > CNT_MAX) ? CNT_MAX : prevPeriod;
    err  = meas - curDiv;
    mag  = (err < 0) ? -err : err;
    if (mag <= TOL) begin
      if (meas == CNT_MAX) modelLockCnt = 0;
      else if (modelLockCnt < LOCK_N) modelLockCnt++;
    end else begin
      stepSize = (mag >= COARSE_THR) ? COARSE_STEP : 1;
      modelIdx = (err > 0) ? modelIdx + stepSize : modelIdx - stepSize;
      if (modelIdx > TRIM_W) modelIdx = TRIM_W;
      if (modelIdx < 0) modelIdx = 0;
      modelLockCnt = 0;
    end
  endtask

  // One osc period of p clock cycles starting with a rising edge at a negedge;
  // outputs are checked three clock edges after the rise.
  task automatic applyStimulus(input int p, input string tag);
    bus.osc = 1'b1;
    for (int c = 0; c < p; c++) begin
      if (c == p / 2) bus.osc = 1'b0;
      if (c == 3) begin
        modelTick();
        checkAll(tag);
      end
      @(negedge clock);
    end
    prevPeriod = p;
  endtask

  // Keep osc low for n more cycles, lengthening the current period.
  task automatic idleLow(input int n);
    repeat (n) @(negedge clock);
    prevPeriod += n;
  endtask

  // Asynchronous reset pulse taken during the low phase of osc.
  task automatic doReset(input string tag);
    #2 reset = 1'b0;
    #1;
    modelTracking = 1'b0;
    modelIdx      = TRIM_INIT;
    modelLockCnt  = 0;
    checkAll(tag);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    idleLow(3);
  endtask

  task automatic setEnable(input bit e);
    bus.enable   = e;
    modelEnabled = e;
    if (!e) begin
      modelTracking = 1'b0;
      modelLockCnt  = 0;
    end
    idleLow(3);
  endtask

  task automatic setDiv(input int d);
    curDiv  = d;
    bus.div = DIV_W'(d);
  endtask

  initial begin
    bus.osc    = 1'b0;
    bus.enable = 1'b1;
    setDiv(8);
    modelEnabled = 1'b1;
    repeat (3) @(negedge clock);
    checkAll("reset");
    reset = 1'b1;
    idleLow(3);

    // div matches the period: trim holds and lock rises on the 4th tracked tick.
    for (int i = 0; i < 7; i++) applyStimulus(8, "match");

    // Reset while locked; the first tick after release only re-arms.
    idleLow(2);
    doReset("rstMid");
    for (int i = 0; i < 3; i++) applyStimulus(8, "afterRst");

    // Clock fast by 3: fine steps up to saturation at TRIM_W.
    doReset("rstB");
    setDiv(5);
    for (int i = 0; i < 16; i++) applyStimulus(8, "fine");

    // Clock fast by 6: coarse steps then saturation.
    doReset("rstC");
    setDiv(2);
    for (int i = 0; i < 7; i++) applyStimulus(8, "coarse");

    // Lock, disable for a while, then retarget to a slower clock.
    doReset("rstD");
    setDiv(8);
    for (int i = 0; i < 6; i++) applyStimulus(8, "preDis");
    setEnable(1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(8, "disabled");
    setDiv(10);
    setEnable(1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(8, "down");

    // A long osc low time saturates the measurement.
    doReset("rstE");
    setDiv(8);
    for (int i = 0; i < 6; i++) applyStimulus(8, "preSat");
    applyStimulus(300, "longPeriod");
    for (int i = 0; i < 6; i++) applyStimulus(8, "postSat");

    // Random periods, targets, enable drops and resets.
    doReset("rstR");
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 4) == 0) setDiv($urandom_range(0, 31));
      if ($urandom_range(0, 29) == 0) begin
        setEnable(1'b0);
        applyStimulus($urandom_range(4, 12), "randDis");
        setEnable(1'b1);
      end
      if ($urandom_range(0, 39) == 0) doReset("randRst");
      if ($urandom_range(0, 24) == 0) applyStimulus($urandom_range(250, 270), "randLong");
      else applyStimulus($urandom_range(4, 24), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/pll_trim_controller.md
PLL_TRIM_CONTROLLER -- requirements
Module: pll_trim_controller

Interface
REQ-001 Parameter DIV_W, default 5, width of the div target input.
REQ-002 Parameter TRIM_W, default 26, width of the thermometer trim output.
REQ-003 Parameter CNT_W, default 8, width of the period counter.
REQ-004 Parameter TOL, default 1, lock window half-width in clock cycles.
REQ-005 Parameter COARSE_THR, default 4, |error| at or above which the coarse step applies.
REQ-006 Parameter COARSE_STEP, default 4, coarse trim step size.
REQ-007 Parameter LOCK_N, default 4, number of consecutive in-window measurements required for lock.
REQ-008 Parameter TRIM_INIT, default 13, trim index after reset (0..TRIM_W).
REQ-009 clock  input  1  single clock; all state is on its rising edge.
REQ-010 reset  input  1  asynchronous, active-low reset.
REQ-011 enable  input  1  loop enable; 0 holds trim.
REQ-012 osc  input  1  reference, asynchronous to clock.
REQ-013 div  input  DIV_W  target count of clock cycles per osc period.
REQ-014 trim  output  TRIM_W  thermometer code, registered.
REQ-015 trim_idx  output  IDX_W=clog2(TRIM_W+1)  binary count of ones in trim, registered.
REQ-016 lock  output  1  loop-locked flag, registered.

Function
REQ-017 The block SHALL pass osc through a 2-flop synchronizer; tick SHALL be high for exactly one cycle, the cycle after the synchronized osc goes 0->1.
REQ-018 The period counter SHALL clear to 0 in each tick cycle, otherwise increment, and saturate at 2^CNT_W-1.
REQ-019 In each tick cycle, meas = counter+1, saturating at 2^CNT_W-1 (clock cycles since the previous tick).
REQ-020 States: IDLE, ARM, TRACK. IDLE->ARM when enable=1. ARM->TRACK on the first tick, with no trim or lock update. Any state->IDLE when enable=0.
REQ-021 In IDLE: counter held at 0; trim and trim_idx held; lock=0.
REQ-022 In TRACK, on each tick, err = meas - div, computed signed in max(CNT_W,DIV_W)+1 bits, with no wrap.
REQ-023 |err| <= TOL: trim unchanged.
REQ-024 err > TOL (clock fast): trim_idx += step.
REQ-025 err < -TOL: trim_idx -= step.
REQ-026 step = COARSE_STEP if |err| >= COARSE_THR, else 1.
REQ-027 trim_idx SHALL saturate at 0 and at TRIM_W, never wrapping.
REQ-028 trim[i] SHALL equal (i < trim_idx) at all times.
REQ-029 trim and trim_idx SHALL update at the clock edge ending the tick cycle, giving 3 clock edges of latency from the first clock edge sampling osc=1.
REQ-030 A lock counter SHALL increment, saturating at LOCK_N, on each in-window tick; it SHALL clear on an out-of-window tick or a saturated meas.
REQ-031 lock = (lock counter == LOCK_N) in TRACK; lock SHALL fall at the edge ending the first out-of-window tick.
REQ-032 div=0 is legal: every meas is >=1, so err > 0 whenever meas > TOL.
REQ-033 A div change takes effect at the next tick; no restart.

Reset
REQ-034 reset=0 SHALL asynchronously force: state IDLE; counter, synchronizer, tick and lock counter to 0; lock=0; trim_idx=TRIM_INIT; trim = TRIM_INIT ones.
REQ-035 Reset deassertion mid-osc-period SHALL re-enter via ARM, so the first partial period is never used for trim.

Verification
REQ-036 clock 10 ns, osc 80 ns period, div=8, enable=1 -> meas=8, trim_idx stays 13, lock=1 at the 4th TRACK tick.
REQ-037 Same clocks, div=5 -> err=+3, trim_idx 13->14->...->26 (+1 per tick), then holds at 26 with lock=0.
REQ-038 Same clocks, div=2 -> err=+6, coarse: 13->17->21->25->26, then saturated.
REQ-039 Locked at div=8, then reset=0 pulsed 20 ns mid-period -> trim_idx=13 and lock=0 immediately; first tick after release causes no update.
REQ-040 Locked, enable=0 for 300 ns, then div=10 and enable=1 -> trim held while IDLE; after ARM, err=-2 -> trim_idx 13->12->...->0.
REQ-041 osc held low 3 us (counter saturates at 255) -> next tick meas=255, lock cleared, trim_idx += COARSE_STEP.
